pc_resolve_unit: RTL and testbench

PC_RESOLVE_UNIT -- requirements
Module: pc_resolve_unit

---
 rtl/pc_resolve_unit_pkg.sv | 13 +
 rtl/sat_counter.sv | 28 ++
 rtl/pc_resolve_unit.sv | 166 ++++++++++++++++
 tb/tb_pc_resolve_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_resolve_unit_pkg.sv
// Shared types and constants for the PC resolve unit: FSM state encoding
// and the default datapath width.
package pc_resolve_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

endpackage : pc_resolve_unit_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Count register: async reset, clear priority, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {CNT_WIDTH{1'b0}};
    end else if (clr) begin
      count <= {CNT_WIDTH{1'b0}};
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule : sat_counter

// File: rtl/pc_resolve_unit.sv
// EX-stage PC resolution: compares the predicted PC against the actual next
// PC, issues a held redirect request to fetch, squashes IF/ID for a fixed
// number of cycles after the handshake, emits predictor updates and keeps
// saturating branch/mispredict statistics.
module pc_resolve_unit
  import pc_resolve_unit_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int ALIGN_BITS   = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_pc,
  input  logic [WIDTH-1:0]     i_alu_rslt,
  input  logic [WIDTH-1:0]     i_ppc,
  input  logic                 i_npc_ctrl,
  input  logic                 i_branch,
  input  logic                 i_jump,
  input  logic                 i_redirect_ready,
  input  logic                 i_cnt_clr,
  output logic                 o_redirect_valid,
  output logic [WIDTH-1:0]     o_redirect_pc,
  output logic                 o_stall,
  output logic                 o_flush,
  output logic                 o_upd_valid,
  output logic [WIDTH-1:0]     o_upd_pc,
  output logic                 o_upd_taken,
  output logic [WIDTH-1:0]     o_upd_target,
  output logic [CNT_WIDTH-1:0] o_br_cnt,
  output logic [CNT_WIDTH-1:0] o_mis_cnt
);

  // Redirect targets are forced to instruction alignment.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));
  // Flush counter value in the last flush cycle (FLUSH_CYCLES is 1..15).
  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e           state_r;
  state_e           next_state_s;
  logic [3:0]       flush_cnt_r;
  logic             ctl_s;
  logic [WIDTH-1:0] actual_npc_s;
  logic             mispredict_s;
  logic             upd_event_s;
  logic             handshake_s;

  // Actual next PC and the qualifying events; only IDLE-state instructions count.
  always_comb begin
    ctl_s = i_branch | i_jump;
    if (!ctl_s || i_npc_ctrl) begin
      actual_npc_s = i_pc;
    end else begin
      actual_npc_s = i_alu_rslt;
    end
    mispredict_s = i_valid && (state_r == ST_IDLE) && (i_ppc != actual_npc_s);
    upd_event_s  = i_valid && (state_r == ST_IDLE) && ctl_s;
    handshake_s  = o_redirect_valid && i_redirect_ready;
  end

  // Next-state logic for IDLE -> REDIRECT -> FLUSH -> IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mispredict_s) begin
          next_state_s = ST_REDIRECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (handshake_s) begin
          next_state_s = ST_FLUSH;
        end else begin
          next_state_s = ST_REDIRECT;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_r == FLUSH_LAST) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_FLUSH;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register and flush-cycle counter (restarts from zero on each FLUSH entry).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 4'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_FLUSH) begin
        flush_cnt_r <= flush_cnt_r + 4'd1;
      end else begin
        flush_cnt_r <= 4'd0;
      end
    end
  end

  // Registered control outputs, derived from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= {WIDTH{1'b0}};
      o_stall          <= 1'b0;
      o_flush          <= 1'b0;
    end else begin
      o_redirect_valid <= (next_state_s == ST_REDIRECT);
      o_stall          <= (next_state_s == ST_REDIRECT);
      o_flush          <= (next_state_s == ST_FLUSH);
      if (mispredict_s) begin
        o_redirect_pc <= actual_npc_s & ALIGN_MASK;
      end else if (handshake_s) begin
        o_redirect_pc <= {WIDTH{1'b0}};
      end else begin
        o_redirect_pc <= o_redirect_pc;
      end
    end
  end

  // Predictor update: one-cycle pulse carrying the resolved control instruction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_upd_valid  <= 1'b0;
      o_upd_pc     <= {WIDTH{1'b0}};
      o_upd_taken  <= 1'b0;
      o_upd_target <= {WIDTH{1'b0}};
    end else begin
      o_upd_valid <= upd_event_s;
      if (upd_event_s) begin
        o_upd_pc     <= i_pc;
        o_upd_taken  <= i_jump | (i_branch & ~i_npc_ctrl);
        o_upd_target <= i_alu_rslt;
      end else begin
        o_upd_pc     <= o_upd_pc;
        o_upd_taken  <= o_upd_taken;
        o_upd_target <= o_upd_target;
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_br_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (upd_event_s),
    .clr   (i_cnt_clr),
    .count (o_br_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mis_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (mispredict_s),
    .clr   (i_cnt_clr),
    .count (o_mis_cnt)
  );

endmodule : pc_resolve_unit

// File: tb/tb_pc_resolve_unit.sv
// Self-checking bench for pc_resolve_unit: a cycle model pushes the expected
// outputs for every clock into a queue, which is popped and compared after
// the edge.
module tb_pc_resolve_unit;

  localparam int W    = 32;
  localparam int FC   = 2;
  localparam int AB   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, npc_ctrl, branch, jump, rdy, cnt_clr;
  logic [W-1:0]  pc, alu, ppc;
  logic          redirect_valid, stall, flush, upd_valid, upd_taken;
  logic [W-1:0]  redirect_pc, upd_pc, upd_target;
  logic [CW-1:0] br_cnt, mis_cnt;

  always #5 clk = ~clk;

  pc_resolve_unit #(.WIDTH(W), .FLUSH_CYCLES(FC), .ALIGN_BITS(AB), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc), .i_alu_rslt(alu),
    .i_ppc(ppc), .i_npc_ctrl(npc_ctrl), .i_branch(branch), .i_jump(jump),
    .i_redirect_ready(rdy), .i_cnt_clr(cnt_clr),
    .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
    .o_stall(stall), .o_flush(flush), .o_upd_valid(upd_valid), .o_upd_pc(upd_pc),
    .o_upd_taken(upd_taken), .o_upd_target(upd_target),
    .o_br_cnt(br_cnt), .o_mis_cnt(mis_cnt)
  );

  typedef struct {
    logic         rv;
    logic [W-1:0] rpc;
    logic         stl, fl, uv;
    logic [W-1:0] upc;
    logic         ut;
    logic [W-1:0] utgt;
    int           br, mis;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           m_st, m_fc, m_br, m_mis;
  logic [W-1:0] m_rpc;
  int           stall_seen, flush_seen;

  // Single comparison point: counts and reports mismatches.
  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] p, input logic [W-1:0] a,
                       input logic [W-1:0] pp, input logic n, input logic b,
                       input logic j, input logic r, input logic c);
    valid = v; pc = p; alu = a; ppc = pp; npc_ctrl = n;
    branch = b; jump = j; rdy = r; cnt_clr = c;
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, r, 1'b0);
      step();
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_fc = 0; m_br = 0; m_mis = 0; m_rpc = '0;
  endtask

  // Advance the model by one clock, push the expectation, clock the DUT, compare.
  task automatic step();
    exp_t         e;
    exp_t         o;
    logic         ctl, mis, ev;
    logic [W-1:0] act;
    ctl = branch | jump;
    act = (!ctl || npc_ctrl) ? pc : alu;
    mis = valid && (m_st == 0) && (ppc != act);
    ev  = valid && (m_st == 0) && ctl;
    e.uv   = ev;
    e.upc  = pc;
    e.ut   = jump || (branch && !npc_ctrl);
    e.utgt = alu;
    if (cnt_clr) begin
      m_br = 0; m_mis = 0;
    end else begin
      if (ev && m_br < CMAX) m_br++;
      if (mis && m_mis < CMAX) m_mis++;
    end
    case (m_st)
      0: if (mis) begin m_st = 1; m_rpc = act & ~((W'(1) << AB) - W'(1)); end
      1: if (rdy) begin m_st = 2; m_fc = 1; end
      default: begin
        if (m_fc == FC) m_st = 0;
        else m_fc++;
      end
    endcase
    e.rv  = (m_st == 1);
    e.stl = (m_st == 1);
    e.fl  = (m_st == 2);
    e.rpc = m_rpc;
    e.br  = m_br;
    e.mis = m_mis;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk_eq("queue_empty", 64'd0, 64'd1);
    end else begin
      o = exp_q.pop_front();
      chk_eq("redirect_valid", 64'(redirect_valid), 64'(o.rv));
      chk_eq("stall", 64'(stall), 64'(o.stl));
      chk_eq("flush", 64'(flush), 64'(o.fl));
      chk_eq("upd_valid", 64'(upd_valid), 64'(o.uv));
      chk_eq("br_cnt", 64'(br_cnt), 64'(o.br));
      chk_eq("mis_cnt", 64'(mis_cnt), 64'(o.mis));
      if (o.rv) chk_eq("redirect_pc", 64'(redirect_pc), 64'(o.rpc));
      if (o.uv) begin
        chk_eq("upd_pc", 64'(upd_pc), 64'(o.upc));
        chk_eq("upd_taken", 64'(upd_taken), 64'(o.ut));
        chk_eq("upd_target", 64'(upd_target), 64'(o.utgt));
      end
    end
    if (stall) stall_seen++;
    if (flush) flush_seen++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_outs"}, 64'({redirect_valid, stall, flush, upd_valid, upd_taken}), 64'd0);
    chk_eq({tag, "_pcs"}, 64'(redirect_pc | upd_pc | upd_target), 64'd0);
    chk_eq({tag, "_cnts"}, 64'({br_cnt, mis_cnt}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] rpc_v;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Correctly predicted taken branch.
    drive(1'b1, 32'h104, 32'h200, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("taken_ok_upd", 64'({upd_valid, upd_taken}), 64'b11);
    chk_eq("taken_ok_tgt", 64'(upd_target), 64'h200);
    idle(1, 1'b0);
    chk_eq("taken_ok_cnt", 64'({br_cnt, mis_cnt}), 64'h10);

    // Mispredict, fetch not ready for 3 cycles: 4 stall cycles then 2 flush cycles.
    stall_seen = 0; flush_seen = 0;
    drive(1'b1, 32'h104, 32'h203, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("mis_redirect_pc", 64'(redirect_pc), 64'h200);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    chk_eq("stall_len", 64'(stall_seen), 64'd4);
    chk_eq("flush_len", 64'(flush_seen), 64'd2);

    // Not-taken branch predicted correctly, and branch+jump treated as a jump.
    drive(1'b1, 32'h300, 32'h500, 32'h300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("nt_taken", 64'(upd_taken), 64'd0);
    drive(1'b1, 32'h310, 32'h620, 32'h620, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_eq("bj_taken", 64'(upd_taken), 64'd1);

    // Wrong-path instructions during REDIRECT and FLUSH are ignored.
    drive(1'b1, 32'h400, 32'h800, 32'h404, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h404, 32'h900, 32'h408, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h408, 32'hA00, 32'h40C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h50C, 32'hB00, 32'h510, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    idle(1, 1'b0);

    // Saturation: 17 mispredicting branches, then clear on an 18th event.
    for (int i = 0; i < 17; i++) begin
      rpc_v = W'($urandom_range(16'hFFF0, 16'h0100)) & ~W'(3);
      drive(1'b1, rpc_v, rpc_v + 32'h100, rpc_v + 32'h4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      idle(3, 1'b1);
    end
    chk_eq("mis_saturated", 64'(mis_cnt), 64'hF);
    drive(1'b1, 32'h600, 32'h700, 32'h604, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk_eq("clr_priority", 64'(mis_cnt), 64'd0);
    idle(3, 1'b1);

    // Reset in the first FLUSH cycle, then a non-control mispredict.
    drive(1'b1, 32'h700, 32'h900, 32'h704, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    idle(1, 1'b1);
    chk_eq("in_flush", 64'(flush), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    chk_all_zero("reset_held");
    rst_n = 1'b1;
    drive(1'b1, 32'h40, 32'h1234, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_eq("nc_redirect_pc", 64'(redirect_pc), 64'h40);
    chk_eq("nc_upd", 64'(upd_valid), 64'd0);
    chk_eq("nc_cnt", 64'({br_cnt, mis_cnt}), 64'h01);
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_resolve_unit
